// File: rtl/alu_pkg.sv
// Shared definitions for the sequential SAP ALU: opcodes, flag bit positions
// and controller state encodings.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    // Positions inside the 4-bit flag word {V,N,Z,C}
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per step.
// product is the accumulator plus the partial product of the bit being
// consumed this cycle, so during the last step it already shows the final
// 2*WIDTH product that the controller captures at that edge.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] partial;

    // Load operands, or add the current partial product and advance one bit
    always_comb begin
        partial  = mplier_q[0] ? mcand_q : '0;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (load) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
        end else if (step) begin
            acc_d    = acc_q + partial;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    assign product = acc_q + partial;

    // Datapath registers; contents are only meaningful after a load
    always_ff @(posedge clk) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU for the SAP datapath: single-cycle add/sub/logic/shift ops,
// a WIDTH-cycle iterative multiply, registered result and {V,N,Z,C} flags,
// and a gated bus driver.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             bus_enable_n,
    output logic [WIDTH-1:0] bus_out,
    input  logic             flag_fi_n,
    input  logic             flag_clear_n,
    output logic [3:0]       flag_out
);

    import alu_pkg::*;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         flags_q, flags_d;
    logic               done_q, done_d;
    logic               mul_load, mul_step;
    logic [2*WIDTH-1:0] product;
    logic               wr;
    logic [WIDTH-1:0]   new_res;
    logic [3:0]         new_flags;
    logic [WIDTH+3:0]   alu_out;
    logic               mul_hi;

    // Evaluate a single-cycle op; returns {flags, result}
    function automatic logic [WIDTH+3:0] alu_eval(input logic [2:0] f_op,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        logic [WIDTH:0]   s;
        logic [WIDTH-1:0] r;
        logic [3:0]       f;
        s = '0;
        r = '0;
        f = '0;
        case (f_op)
            OP_ADD: begin
                s         = {1'b0, x} + {1'b0, y};
                r         = s[WIDTH-1:0];
                f[FLAG_C] = s[WIDTH];
                f[FLAG_V] = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SUB: begin
                s         = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
                r         = s[WIDTH-1:0];
                f[FLAG_C] = s[WIDTH];
                f[FLAG_V] = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
            end
            OP_AND: r = x & y;
            OP_OR:  r = x | y;
            OP_XOR: r = x ^ y;
            OP_SHL: begin
                r         = {x[WIDTH-2:0], 1'b0};
                f[FLAG_C] = x[WIDTH-1];
            end
            OP_SHR: begin
                r         = {1'b0, x[WIDTH-1:1]};
                f[FLAG_C] = x[0];
            end
            default: r = '0;
        endcase
        f[FLAG_Z] = (r == '0);
        f[FLAG_N] = r[WIDTH-1];
        return {f, r};
    endfunction

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .load    (mul_load),
        .step    (mul_step),
        .a       (a),
        .b       (b),
        .product (product)
    );

    // Next-state, multiplier control and result/flag register updates
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        mul_load  = 1'b0;
        mul_step  = 1'b0;
        wr        = 1'b0;
        new_res   = '0;
        new_flags = '0;
        alu_out   = alu_eval(op, a, b);
        mul_hi    = |product[2*WIDTH-1:WIDTH];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        mul_load = 1'b1;
                        cnt_d    = '0;
                        state_d  = S_RUN;
                    end else begin
                        wr        = 1'b1;
                        new_res   = alu_out[WIDTH-1:0];
                        new_flags = alu_out[WIDTH+3:WIDTH];
                    end
                end
            end
            S_RUN: begin
                mul_step = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d           = S_IDLE;
                    wr                = 1'b1;
                    new_res           = product[WIDTH-1:0];
                    new_flags[FLAG_C] = mul_hi;
                    new_flags[FLAG_V] = mul_hi;
                    new_flags[FLAG_Z] = (product[WIDTH-1:0] == '0);
                    new_flags[FLAG_N] = product[WIDTH-1];
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr) begin
            result_d = new_res;
            done_d   = 1'b1;
        end

        // Clear wins over a load in the same cycle
        if (!flag_clear_n) begin
            flags_d = '0;
        end else if (wr && !flag_fi_n) begin
            flags_d = new_flags;
        end
    end

    // Control and result/flag registers; reset aborts any multiply in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = done_q;
    assign flag_out = flags_q;
    assign bus_out  = bus_enable_n ? '0 : result_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8 with hand-computed expectations.
module tb_alu_seq;

    import alu_pkg::*;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] a, b;
    logic [2:0]       op;
    logic             start;
    logic             busy, done;
    logic             bus_enable_n;
    logic [WIDTH-1:0] bus_out;
    logic             flag_fi_n, flag_clear_n;
    logic [3:0]       flag_out;

    int n_vec = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a            (a),
        .b            (b),
        .op           (op),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .bus_enable_n (bus_enable_n),
        .bus_out      (bus_out),
        .flag_fi_n    (flag_fi_n),
        .flag_clear_n (flag_clear_n),
        .flag_out     (flag_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue a single-cycle op at a falling edge; check one cycle later
    task automatic single(input string tag, input logic [2:0] o, input logic [7:0] x,
                          input logic [7:0] y, input logic [7:0] er, input logic [3:0] ef);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".bus"}, 32'(bus_out), 32'(er));
        check({tag, ".flags"}, 32'(flag_out), 32'(ef));
    endtask

    // Issue a multiply, optionally poke start while busy, check latency/result
    task automatic mul_run(input string tag, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] er, input logic [3:0] ef, input bit poke);
        int k;
        @(negedge clk);
        op = OP_MUL; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".busy0"}, 32'(busy), 32'd1);
        k = 0;
        while (done !== 1'b1 && k < 20) begin
            start = poke && (k == 3 || k == WIDTH - 1);
            if (start) begin
                op = OP_ADD; a = 8'h01; b = 8'h01;
            end
            @(negedge clk);
            k++;
            if (k < WIDTH) check({tag, ".busy"}, 32'(busy), 32'd1);
        end
        start = 1'b0;
        check({tag, ".latency"}, 32'(k), 32'(WIDTH));
        check({tag, ".busy_end"}, 32'(busy), 32'd0);
        check({tag, ".bus"}, 32'(bus_out), 32'(er));
        check({tag, ".flags"}, 32'(flag_out), 32'(ef));
        @(negedge clk);
        check({tag, ".done_drop"}, 32'(done), 32'd0);
        check({tag, ".hold"}, 32'(bus_out), 32'(er));
        check({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int dcount;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; op = OP_ADD;
        flag_fi_n = 1'b0; flag_clear_n = 1'b1; bus_enable_n = 1'b0;
        #1;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.bus", 32'(bus_out), 32'd0);
        check("rst.flags", 32'(flag_out), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Arithmetic
        single("add1", OP_ADD, 8'h01, 8'h01, 8'h02, 4'b0000);
        @(negedge clk);
        check("add1.done_drop", 32'(done), 32'd0);
        single("add2", OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b0011);
        single("sub1", OP_SUB, 8'h04, 8'h01, 8'h03, 4'b0001);
        single("sub2", OP_SUB, 8'h01, 8'h04, 8'hFD, 4'b0100);
        single("sub3", OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b1001);
        single("add_v", OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b1100);

        // Multiply
        mul_run("mul1", 8'h0D, 8'h0B, 8'h8F, 4'b0100, 1'b1);
        mul_run("mul2", 8'h20, 8'h10, 8'h00, 4'b1011, 1'b0);

        // Shifts and logic
        single("shl", OP_SHL, 8'h81, 8'h00, 8'h02, 4'b0001);
        single("shr", OP_SHR, 8'h01, 8'h00, 8'h00, 4'b0011);
        single("xor", OP_XOR, 8'hAA, 8'hAA, 8'h00, 4'b0010);
        single("or",  OP_OR,  8'hF0, 8'h0F, 8'hFF, 4'b0100);
        single("and", OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000);

        // Flag control: load suppressed, then clear coinciding with done
        single("fset", OP_SUB, 8'h01, 8'h04, 8'hFD, 4'b0100);
        flag_fi_n = 1'b1;
        single("fhold", OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b0100);
        flag_fi_n = 1'b0;
        flag_clear_n = 1'b0;
        single("fclr", OP_ADD, 8'h01, 8'h02, 8'h03, 4'b0000);
        flag_clear_n = 1'b1;

        // Bus gating is combinational
        @(negedge clk);
        bus_enable_n = 1'b1;
        #1;
        check("bus_off", 32'(bus_out), 32'd0);
        bus_enable_n = 1'b0;
        #1;
        check("bus_on", 32'(bus_out), 32'h03);

        // Reset in the middle of a multiply
        single("pre_rst", OP_SUB, 8'h01, 8'h04, 8'hFD, 4'b0100);
        @(negedge clk);
        op = OP_MUL; a = 8'h0D; b = 8'h0B; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check("abort.bus", 32'(bus_out), 32'd0);
        check("abort.flags", 32'(flag_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("abort.no_done", 32'(dcount), 32'd0);
        check("abort.bus_hold", 32'(bus_out), 32'd0);
        single("post_rst", OP_ADD, 8'h01, 8'h01, 8'h02, 4'b0000);
        mul_run("mul3", 8'h03, 8'h05, 8'h0F, 4'b0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
